pwm_seq_ctrl: RTL



---
 rtl/pwm_seq_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: drives the combination-lock status LED.
// A free-running PWM counter sets the LED duty in eighths. A small FSM plays
// a brightness ramp after a correct code and a blink pattern after a wrong one.
// All outputs are registered. The FSM holds a 12.5% standby glow while idle.
module pwm_seq_ctrl #(
    parameter int CNT_W       = 12,
    parameter int TICK_CYCLES = 25000000,
    parameter int NUM_BLINKS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ok_req,
    input  logic       fail_req,
    output logic       led_pwm,
    output logic [3:0] duty_level,
    output logic       busy,
    output logic       done
);

    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int STEP_W = $clog2(2 * NUM_BLINKS + 4) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [STEP_W-1:0] FAIL_LAST = STEP_W'(2 * NUM_BLINKS - 1);
    // The ramp ends on the 4th tick spent at full brightness.
    localparam logic [STEP_W-1:0] HOLD_LAST = STEP_W'(3);

    localparam logic [3:0] DUTY_IDLE = 4'd1;
    localparam logic [3:0] DUTY_RAMP = 4'd2;
    localparam logic [3:0] DUTY_FULL = 4'd8;
    localparam logic [3:0] DUTY_OFF  = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_OK_RAMP    = 2'd1,
        ST_FAIL_BLINK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [3:0]        duty_level_q, duty_level_d;
    logic              led_pwm_q, led_pwm_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tick_s;

    // Sequence step strobe: fires once every TICK_CYCLES cycles while a sequence runs.
    always_comb begin
        tick_s = (state_q != ST_IDLE) && (tick_cnt_q == TICK_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; fail has priority over ok, and requests only matter in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fail_req) begin
                    state_d = ST_FAIL_BLINK;
                end else if (ok_req) begin
                    state_d = ST_OK_RAMP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OK_RAMP: begin
                if (tick_s && (duty_level_q == DUTY_FULL) && (step_cnt_q == HOLD_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OK_RAMP;
                end
            end
            ST_FAIL_BLINK: begin
                if (tick_s && (step_cnt_q == FAIL_LAST)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FAIL_BLINK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters: PWM free-runs; tick and step counters sit at zero in IDLE so each sequence starts clean.
    always_comb begin
        cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        tick_cnt_d = {TICK_W{1'b0}};
        step_cnt_d = step_cnt_q;
        if (state_q == ST_IDLE) begin
            tick_cnt_d = {TICK_W{1'b0}};
            step_cnt_d = {STEP_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_d = {TICK_W{1'b0}};
            if ((state_q == ST_FAIL_BLINK) || (duty_level_q == DUTY_FULL)) begin
                step_cnt_d = step_cnt_q + {{(STEP_W-1){1'b0}}, 1'b1};
            end else begin
                step_cnt_d = step_cnt_q;
            end
        end else begin
            tick_cnt_d = tick_cnt_q + {{(TICK_W-1){1'b0}}, 1'b1};
            step_cnt_d = step_cnt_q;
        end
    end

    // Output logic: next duty, busy, done and PWM values, all registered below.
    always_comb begin
        duty_level_d = duty_level_q;
        led_pwm_d    = ({1'b0, cnt_q[CNT_W-1 -: 3]} < duty_level_q);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_q != ST_IDLE) && (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_FAIL_BLINK) begin
                    duty_level_d = DUTY_FULL;
                end else if (state_d == ST_OK_RAMP) begin
                    duty_level_d = DUTY_RAMP;
                end else begin
                    duty_level_d = DUTY_IDLE;
                end
            end
            ST_OK_RAMP: begin
                if (state_d == ST_IDLE) begin
                    duty_level_d = DUTY_IDLE;
                end else if (tick_s && (duty_level_q < DUTY_FULL)) begin
                    duty_level_d = duty_level_q + 4'd1;
                end else begin
                    duty_level_d = duty_level_q;
                end
            end
            ST_FAIL_BLINK: begin
                if (state_d == ST_IDLE) begin
                    duty_level_d = DUTY_IDLE;
                end else if (tick_s) begin
                    duty_level_d = (duty_level_q == DUTY_FULL) ? DUTY_OFF : DUTY_FULL;
                end else begin
                    duty_level_d = duty_level_q;
                end
            end
            default: begin
                duty_level_d = DUTY_IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= {CNT_W{1'b0}};
            tick_cnt_q   <= {TICK_W{1'b0}};
            step_cnt_q   <= {STEP_W{1'b0}};
            duty_level_q <= DUTY_IDLE;
            led_pwm_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            tick_cnt_q   <= tick_cnt_d;
            step_cnt_q   <= step_cnt_d;
            duty_level_q <= duty_level_d;
            led_pwm_q    <= led_pwm_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign led_pwm    = led_pwm_q;
    assign duty_level = duty_level_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
